// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the round-robin data-memory arbiter.
package dmem_arb_pkg;

   localparam int unsigned N_REQ_DEF  = 4;
   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] index
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic               found;
   logic [IDX_W:0]     sum;

   // Doubling the vector turns the wrap-around scan into a plain slice.
   assign dbl = {req, req};
   assign rot = dbl[rr_ptr +: N_REQ];

   always_comb begin
      found = 1'b0;
      sum   = '0;
      gnt   = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (rot[j] && !found) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr} + (IDX_W+1)'(j);
         end
      end
      if (sum >= (IDX_W+1)'(N_REQ)) begin
         sum = sum - (IDX_W+1)'(N_REQ);
      end
      index = sum[IDX_W-1:0];
      if (found) begin
         gnt[index] = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between N_REQ cores,
// one transaction in flight at a time.
module dmem_rr_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned N_REQ  = N_REQ_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                     clock,
   input  logic                     async_reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         we,
   input  logic [N_REQ*ADDR_W-1:0]  addr,
   input  logic [N_REQ*DATA_W-1:0]  wdata,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         stall,
   output logic [DATA_W-1:0]        rdata,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   win_idx;
   logic [N_REQ-1:0]   win_gnt;
   logic               load_en;
   logic               done;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               sel_we;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .gnt    (win_gnt),
      .index  (win_idx)
   );

   // One-hot AND-OR mux of the winning core's request fields.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_gnt[i]) begin
            sel_addr  = sel_addr  | addr[i*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | wdata[i*DATA_W +: DATA_W];
            sel_we    = sel_we    | we[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      load_en  = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               load_en = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_we) begin
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         RESP: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (done) begin
         rr_ptr_d = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clock or posedge async_reset) begin
      if (async_reset) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         if (load_en) begin
            owner_q   <= win_idx;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
      end
   end

   always_comb begin
      ack = '0;
      if (done) begin
         ack[owner_q] = 1'b1;
      end
   end

   assign stall  = req & ~ack;
   assign mem_en = (state_q == ISSUE);
   assign rdata  = (state_q == RESP) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed vector bench for dmem_rr_arbiter with a behavioural 1-cycle RAM.
module tb_dmem_rr_arbiter;

   logic          clock = 1'b0;
   logic          async_reset;
   logic [3:0]    req, we, ack, stall;
   logic [127:0]  addr, wdata;
   logic [31:0]   rdata, mem_addr, mem_wdata, mem_rdata;
   logic          mem_en, mem_we;

   int n_vec = 0;
   int n_err = 0;

   dmem_rr_arbiter #(
      .N_REQ  (4),
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clock       (clock),
      .async_reset (async_reset),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .ack         (ack),
      .stall       (stall),
      .rdata       (rdata),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clock = ~clock;

   // RAM model: unwritten words return a fixed preload pattern.
   logic [31:0] ram [256];
   bit          ram_valid [256];

   function automatic logic [31:0] init_word(input logic [7:0] idx);
      if (idx == 8'd16) return 32'hDEADBEEF;
      if (idx < 8'd4) return 32'hC0DE0000 | {24'd0, idx};
      return 32'h0;
   endfunction

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr[9:2]]       <= mem_wdata;
            ram_valid[mem_addr[9:2]] <= 1'b1;
         end else begin
            mem_rdata <= ram_valid[mem_addr[9:2]] ? ram[mem_addr[9:2]]
                                                  : init_word(mem_addr[9:2]);
         end
      end
   end

   typedef struct {
      string        name;
      logic [3:0]   req;
      logic [3:0]   we;
      logic [127:0] addr;
      logic [127:0] wdata;
      logic [3:0]   ack;
      logic [3:0]   stall;
      logic         en;
      logic         mwe;
      logic [31:0]  maddr;
      logic [31:0]  mwd;
      logic [31:0]  rd;
      logic         chk_rd;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [127:0] pack4(input logic [31:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic vec_t mk(input string n, input logic [3:0] rq, w,
                               input logic [127:0] a, wd, input logic [3:0] ak, st,
                               input logic en, mwe, input logic [31:0] ma, mw, rd,
                               input logic crd);
      vec_t v;
      v.name = n; v.req = rq; v.we = w; v.addr = a; v.wdata = wd; v.ack = ak;
      v.stall = st; v.en = en; v.mwe = mwe; v.maddr = ma; v.mwd = mw; v.rd = rd;
      v.chk_rd = crd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_vec(input vec_t v);
      chk({v.name, ".ack"}, {28'd0, ack}, {28'd0, v.ack});
      chk({v.name, ".stall"}, {28'd0, stall}, {28'd0, v.stall});
      chk({v.name, ".mem_en"}, {31'd0, mem_en}, {31'd0, v.en});
      if (v.en) begin
         chk({v.name, ".mem_addr"}, mem_addr, v.maddr);
         chk({v.name, ".mem_we"}, {31'd0, mem_we}, {31'd0, v.mwe});
         if (v.mwe) chk({v.name, ".mem_wdata"}, mem_wdata, v.mwd);
      end
      if (v.chk_rd) chk({v.name, ".rdata"}, rdata, v.rd);
   endtask

   initial begin
      logic [127:0] a1, a2, w2, a5, w5, a0, ac;
      logic [3:0]   pending;

      a1 = pack4(32'h0, 32'h40, 32'h0, 32'h0);
      a0 = pack4(32'h40, 32'h0, 32'h0, 32'h0);
      a2 = pack4(32'h0, 32'h0, 32'h80, 32'h0);
      w2 = pack4(32'h0, 32'h0, 32'h12345678, 32'h0);
      a5 = pack4(32'h100, 32'h0, 32'h0, 32'h300);
      w5 = pack4(32'h0A0A, 32'h0, 32'h0, 32'h3B3B);
      ac = pack4(32'h0, 32'h4, 32'h8, 32'hC);

      // Single load by core1, then idle (rr_ptr -> 2).
      tbl.push_back(mk("ld_idle",  4'b0010, 4'b0000, a1, '0, 4'b0000, 4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("ld_issue", 4'b0010, 4'b0000, a1, '0, 4'b0000, 4'b0010, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("ld_resp",  4'b0010, 4'b0000, a1, '0, 4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1));
      tbl.push_back(mk("idle_a",   4'b0000, 4'b0000, a1, '0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      // Store by core2 and read-back (rr_ptr -> 3).
      tbl.push_back(mk("st_idle",  4'b0100, 4'b0100, a2, w2, 4'b0000, 4'b0100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("st_issue", 4'b0100, 4'b0100, a2, w2, 4'b0100, 4'b0000, 1'b1, 1'b1, 32'h80, 32'h12345678, 32'h0, 1'b0));
      tbl.push_back(mk("rb_idle",  4'b0100, 4'b0000, a2, '0, 4'b0000, 4'b0100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("rb_issue", 4'b0100, 4'b0000, a2, '0, 4'b0000, 4'b0100, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("rb_resp",  4'b0100, 4'b0000, a2, '0, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b1));
      tbl.push_back(mk("idle_b",   4'b0000, 4'b0000, a2, '0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      // Wrap: rr_ptr=3, req=1001 -> core3 then core0 (rr_ptr -> 1).
      tbl.push_back(mk("wr_idle3", 4'b1001, 4'b1001, a5, w5, 4'b0000, 4'b1001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("wr_iss3",  4'b1001, 4'b1001, a5, w5, 4'b1000, 4'b0001, 1'b1, 1'b1, 32'h300, 32'h3B3B, 32'h0, 1'b0));
      tbl.push_back(mk("wr_idle0", 4'b0001, 4'b1001, a5, w5, 4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("wr_iss0",  4'b0001, 4'b1001, a5, w5, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h100, 32'h0A0A, 32'h0, 1'b0));
      tbl.push_back(mk("idle_c",   4'b0000, 4'b0000, a5, w5, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      // Fairness: cores 0 and 3 store continuously, grants alternate 3,0,3,0.
      for (int k = 0; k < 2; k++) begin
         tbl.push_back(mk("f_idle3", 4'b1001, 4'b1001, a5, w5, 4'b0000, 4'b1001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
         tbl.push_back(mk("f_gnt3",  4'b1001, 4'b1001, a5, w5, 4'b1000, 4'b0001, 1'b1, 1'b1, 32'h300, 32'h3B3B, 32'h0, 1'b0));
         tbl.push_back(mk("f_idle0", 4'b1001, 4'b1001, a5, w5, 4'b0000, 4'b1001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
         tbl.push_back(mk("f_gnt0",  4'b1001, 4'b1001, a5, w5, 4'b0001, 4'b1000, 1'b1, 1'b1, 32'h100, 32'h0A0A, 32'h0, 1'b0));
      end
      tbl.push_back(mk("idle_d",   4'b0000, 4'b0000, a5, w5, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      // Owner drops req after grant: transaction still completes (rr_ptr stays 1).
      tbl.push_back(mk("do_idle",  4'b0001, 4'b0000, a0, '0, 4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("do_issue", 4'b0000, 4'b0000, a0, '0, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("do_resp",  4'b0000, 4'b0000, a0, '0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1));
      // Non-owner core0 withdraws while core1 is served.
      tbl.push_back(mk("wd_idle",  4'b0011, 4'b0000, ac, '0, 4'b0000, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("wd_issue", 4'b0010, 4'b0000, ac, '0, 4'b0000, 4'b0010, 1'b1, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("wd_resp",  4'b0010, 4'b0000, ac, '0, 4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC0DE0001, 1'b1));
      tbl.push_back(mk("idle_e",   4'b0000, 4'b0000, ac, '0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      tbl.push_back(mk("idle_f",   4'b0000, 4'b0000, ac, '0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));

      async_reset = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0;
      step();
      step();
      chk("rst.ack", {28'd0, ack}, 32'h0);
      chk("rst.mem_en", {31'd0, mem_en}, 32'h0);
      chk("rst.mem_we", {31'd0, mem_we}, 32'h0);
      chk("rst.mem_addr", mem_addr, 32'h0);
      chk("rst.mem_wdata", mem_wdata, 32'h0);
      chk("rst.rdata", rdata, 32'h0);
      async_reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
         #1;
         check_vec(tbl[i]);
         step();
      end

      // Reset during RESP of a core1 load.
      req = 4'b0010; we = '0; addr = a1;
      #1;
      chk("r6.idle_stall", {28'd0, stall}, 32'h2);
      step();
      chk("r6.issue_en", {31'd0, mem_en}, 32'h1);
      step();
      chk("r6.resp_ack", {28'd0, ack}, 32'h2);
      async_reset = 1'b1;
      #1;
      chk("r6.rst_ack", {28'd0, ack}, 32'h0);
      chk("r6.rst_mem_en", {31'd0, mem_en}, 32'h0);
      chk("r6.rst_rdata", rdata, 32'h0);
      chk("r6.rst_stall", {28'd0, stall}, 32'h2);
      step();
      async_reset = 1'b0;
      req = '0;
      #1;
      chk("r6.post_en", {31'd0, mem_en}, 32'h0);
      step();
      req = 4'b0100; addr = a2;
      #1;
      chk("r6.c2_idle_stall", {28'd0, stall}, 32'h4);
      chk("r6.c2_idle_en", {31'd0, mem_en}, 32'h0);
      step();
      chk("r6.c2_issue_en", {31'd0, mem_en}, 32'h1);
      chk("r6.c2_issue_addr", mem_addr, 32'h80);
      chk("r6.c2_issue_ack", {28'd0, ack}, 32'h0);
      step();
      chk("r6.c2_resp_ack", {28'd0, ack}, 32'h4);
      chk("r6.c2_resp_rdata", rdata, 32'h12345678);
      req = '0;
      step();

      // Contention after reset: all four load together, served 0,1,2,3.
      async_reset = 1'b1;
      step();
      async_reset = 1'b0;
      pending = 4'b1111;
      addr = ac; we = '0;
      for (int k = 0; k < 4; k++) begin
         req = pending;
         #1;
         chk($sformatf("ct%0d.idle_ack", k), {28'd0, ack}, 32'h0);
         chk($sformatf("ct%0d.idle_stall", k), {28'd0, stall}, {28'd0, pending});
         step();
         chk($sformatf("ct%0d.issue_en", k), {31'd0, mem_en}, 32'h1);
         chk($sformatf("ct%0d.issue_addr", k), mem_addr, 32'(4 * k));
         chk($sformatf("ct%0d.issue_stall", k), {28'd0, stall}, {28'd0, pending});
         step();
         chk($sformatf("ct%0d.resp_ack", k), {28'd0, ack}, 32'h1 << k);
         chk($sformatf("ct%0d.resp_rdata", k), rdata, 32'hC0DE0000 + 32'(k));
         chk($sformatf("ct%0d.resp_stall", k), {28'd0, stall},
             {28'd0, pending & ~(4'b0001 << k)});
         pending[k] = 1'b0;
         step();
      end
      req = '0;
      #1;
      chk("ct.final_en", {31'd0, mem_en}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
